// File: rtl/cnn_div_pkg.sv
// cnn_div_pkg: shared types, default widths and saturation limits for the CNN divider/requantiser
package cnn_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    localparam int DIV_WIDTH_N = 14;
    localparam int DIV_WIDTH_D = 5;
    localparam int DIV_WIDTH_Q = 9;

    function automatic int q_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int q_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int DIV_Q_MAX = q_max(DIV_WIDTH_Q);
    localparam int DIV_Q_MIN = q_min(DIV_WIDTH_Q);

endpackage

// File: rtl/div_sat_sign.sv
// div_sat_sign: applies signs to magnitude quotient/remainder, saturates quotient, flags overflow
//   mag_q_i/mag_r_i : unsigned magnitudes      neg_q_i/neg_r_i : result signs
//   dbz_i           : divide-by-zero override  quo_o/rem_o/ovf_o : signed results and clip flag
module div_sat_sign
    import cnn_div_pkg::*;
#(
    parameter int WN = DIV_WIDTH_N,
    parameter int WD = DIV_WIDTH_D,
    parameter int WQ = DIV_WIDTH_Q
) (
    input  logic [WN-1:0] mag_q_i,
    input  logic [WD-1:0] mag_r_i,
    input  logic          neg_q_i,
    input  logic          neg_r_i,
    input  logic          dbz_i,
    output logic [WQ-1:0] quo_o,
    output logic [WD-1:0] rem_o,
    output logic          ovf_o
);
    localparam logic [WQ-1:0] Q_MAX   = WQ'(q_max(WQ));
    localparam logic [WQ-1:0] Q_MIN   = WQ'(q_min(WQ));
    localparam logic [WN-1:0] POS_LIM = WN'(q_max(WQ));
    localparam logic [WN-1:0] NEG_LIM = WN'(-q_min(WQ));

    logic clip;

    // a negative result may reach one step further than a positive one
    assign clip  = neg_q_i ? (mag_q_i > NEG_LIM) : (mag_q_i > POS_LIM);
    assign quo_o = (dbz_i || clip) ? (neg_q_i ? Q_MIN : Q_MAX)
                 : neg_q_i ? -mag_q_i[WQ-1:0] : mag_q_i[WQ-1:0];
    assign ovf_o = !dbz_i && clip;
    assign rem_o = dbz_i ? '0 : neg_r_i ? -mag_r_i : mag_r_i;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring signed divider, one quotient bit per clock, valid/ready both sides
//   in_valid/in_ready/dividend/divisor : request side, sampled only on the accepting edge
//   out_valid/out_ready                : response side, results held until accepted
//   quotient/remainder/overflow/div_by_zero : saturated signed results and flags
module seq_divider
    import cnn_div_pkg::*;
#(
    parameter int WIDTH_N = DIV_WIDTH_N,
    parameter int WIDTH_D = DIV_WIDTH_D,
    parameter int WIDTH_Q = DIV_WIDTH_Q
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_Q-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               overflow,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH_N);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d, calc_dvd;
    logic [WIDTH_D-1:0] dsr_q, dsr_d, rem_q, rem_d, calc_rem;
    logic               sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d;
    logic [WIDTH_Q-1:0] quo_q, quo_d, sat_quo;
    logic [WIDTH_D-1:0] rmo_q, rmo_d, sat_rem;
    logic               ovf_q, ovf_d, dbz_q, dbz_d, sat_ovf;
    logic [WIDTH_D:0]   shifted, trial;

    // dividend register shifts its MSB into the partial remainder and takes quotient bits in at the LSB
    assign shifted  = {rem_q, dvd_q[WIDTH_N-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign calc_dvd = {dvd_q[WIDTH_N-2:0], ~trial[WIDTH_D]};
    assign calc_rem = trial[WIDTH_D] ? shifted[WIDTH_D-1:0] : trial[WIDTH_D-1:0];

    // in IDLE the formatter only serves the divide-by-zero path, signed by the live dividend
    div_sat_sign #(.WN(WIDTH_N), .WD(WIDTH_D), .WQ(WIDTH_Q)) u_sat (
        .mag_q_i (calc_dvd),
        .mag_r_i (calc_rem),
        .neg_q_i (state_q == IDLE ? dividend[WIDTH_N-1] : sgn_q_q),
        .neg_r_i (sgn_r_q),
        .dbz_i   (state_q == IDLE),
        .quo_o   (sat_quo),
        .rem_o   (sat_rem),
        .ovf_o   (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dvd_d   = dividend[WIDTH_N-1] ? -dividend : dividend;
                dsr_d   = divisor[WIDTH_D-1] ? -divisor : divisor;
                rem_d   = '0;
                sgn_q_d = dividend[WIDTH_N-1] ^ divisor[WIDTH_D-1];
                sgn_r_d = dividend[WIDTH_N-1];
                cnt_d   = CW'(WIDTH_N - 1);
                state_d = divisor == '0 ? DONE : CALC;
                if (divisor == '0) begin
                    quo_d = sat_quo;
                    rmo_d = sat_rem;
                    ovf_d = sat_ovf;
                    dbz_d = 1'b1;
                end
            end
            CALC: begin
                dvd_d = calc_dvd;
                rem_d = calc_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = sat_quo;
                    rmo_d   = sat_rem;
                    ovf_d   = sat_ovf;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                quo_d   = '0;
                rmo_d   = '0;
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            quo_q   <= '0;
            rmo_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign quotient    = quo_q;
    assign remainder   = rmo_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider against an integer-arithmetic reference model
module tb_seq_divider;

    localparam int WN   = 14;
    localparam int WD   = 5;
    localparam int QMAX = 255;
    localparam int QMIN = -256;

    typedef struct {
        int q;
        int r;
        int ov;
        int dz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WN-1:0] dividend;
    logic [WD-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    quotient;
    logic [WD-1:0] remainder;
    logic          overflow;
    logic          div_by_zero;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.dz = 1; e.ov = 0; e.r = 0;
            e.q  = (a < 0) ? QMIN : QMAX;
        end else begin
            e.dz = 0;
            e.q  = a / b;
            e.r  = a % b;
            e.ov = (e.q > QMAX || e.q < QMIN) ? 1 : 0;
            if (e.q > QMAX) e.q = QMAX;
            if (e.q < QMIN) e.q = QMIN;
        end
        return e;
    endfunction

    // monitor: compares every accepted result against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", int'($signed(quotient)), e.q);
                    chk("remainder", int'($signed(remainder)), e.r);
                    chk("overflow", int'(overflow), e.ov);
                    chk("div_by_zero", int'(div_by_zero), e.dz);
                end
            end
        end
    end

    task automatic run_op(input int a, input int b, input int hold);
        exp_t e;
        int   n;
        e = model(a, b);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        dividend = WN'(a);
        divisor  = WD'(b);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = WN'($urandom);
        divisor  = WD'($urandom);
        // the accepting edge counts as edge 1
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, (b == 0) ? 1 : 15);
        repeat (hold) begin
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_quotient", int'($signed(quotient)), e.q);
            chk("bp_remainder", int'($signed(remainder)), e.r);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
    endtask

    task automatic reset_mid_calc();
        int seen;
        in_valid = 1'b1;
        dividend = WN'(100);
        divisor  = WD'(7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("calc_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_in_ready", int'(in_ready), 1);
        chk("rst_async_out_valid", int'(out_valid), 0);
        chk("rst_async_quotient", int'(quotient), 0);
        chk("rst_async_remainder", int'(remainder), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_release_in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_stale_out_valid", seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_div_by_zero", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(100, 7, 0);
        run_op(-100, 7, 0);
        run_op(100, -7, 0);
        run_op(-100, -7, 0);
        run_op(5000, 3, 0);
        run_op(-8192, 1, 0);
        run_op(255, 1, 0);
        run_op(-256, 1, 0);
        run_op(8191, -16, 0);
        run_op(37, 0, 0);
        run_op(-37, 0, 0);
        run_op(1234, 5, 5);
        run_op(-3, 9, 0);
        reset_mid_calc();
        run_op(100, 7, 0);

        repeat (40) begin
            a = int'($urandom_range(0, 16383)) - 8192;
            b = int'($urandom_range(0, 31)) - 16;
            if ($urandom_range(0, 1) == 0) a = a / 64;
            run_op(a, b, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative signed integer divider; the inverse operation of the CNN datapath multiplier.
- Takes a WIDTH_N-bit signed dividend (multiplier-product width) and a WIDTH_D-bit signed divisor.
- Returns a saturated WIDTH_Q-bit signed quotient and a WIDTH_D-bit signed remainder.
- Used for average-pooling normalisation and requantisation of accumulated products back to activation width.
- Restoring algorithm, one quotient bit per clock, valid/ready handshake on both sides.

Parameters:
WIDTH_N, 14, dividend width (equals multiplier product width 9+5)
WIDTH_D, 5, divisor and remainder width
WIDTH_Q, 9, output quotient width (activation width)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept an operation
dividend  input  WIDTH_N  signed dividend
divisor  input  WIDTH_D  signed divisor
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
quotient  output  WIDTH_Q  signed quotient, truncated toward zero, saturated
remainder  output  WIDTH_D  signed remainder, sign follows dividend
overflow  output  1  quotient saturated
div_by_zero  output  1  divisor was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, iteration counter=0.
- Reset mid-operation aborts immediately. No result is emitted.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Latch |dividend| and |divisor| as unsigned WIDTH_N / WIDTH_D magnitudes. |-2^(WIDTH_N-1)| must be represented correctly with no wrap.
  - If divisor==0, go to DONE. Otherwise load counter=WIDTH_N-1 and go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: shift partial remainder left, bringing in the next dividend MSB; trial-subtract |divisor|; set quotient bit if the result is non-negative, else restore.
  - Counter decrements. When counter==0, go to DONE.
  - Exactly WIDTH_N cycles are spent in CALC.
- DONE:
  - out_valid=1 and outputs are stable until out_ready.
  - On out_valid&&out_ready, go to IDLE; out_valid drops on the next edge.
  - in_ready stays 0 in DONE. A new request is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Nonzero divisor: out_valid rises WIDTH_N+1 edges after the accepting edge (15 for defaults).
  - Zero divisor: out_valid rises 1 edge after the accepting edge.
- Result formation, registered on entry to DONE:
  - Apply sign_q to the full WIDTH_N-bit magnitude quotient.
  - Saturate to [-2^(WIDTH_Q-1), 2^(WIDTH_Q-1)-1]. Set overflow=1 if clipped.
  - Remainder = magnitude remainder with sign_r applied. |r| < |divisor| always fits in WIDTH_D.
- Divide by zero: div_by_zero=1, overflow=0, remainder=0. Quotient = max positive if dividend>=0, otherwise min negative.
- Flags are valid only while out_valid=1. They are cleared on the transition to IDLE.
- Inputs are sampled only at the accepting edge. Changes at any other time are ignored.

Decomposition:
- Shared package cnn_div_pkg holds:
  - FSM state enum (IDLE/CALC/DONE).
  - Default width constants DIV_WIDTH_N/D/Q, tied to the multiplier widths.
  - Saturation limit constants derived from WIDTH_Q.
- One natural sub-module: div_sat_sign, combinational sign application plus saturation and flag generation. It is reusable by the requantiser.
- The iteration core stays in seq_divider.

Test Plan:
- 100/7 -> quotient=14, remainder=2, overflow=0, div_by_zero=0. out_valid exactly 15 cycles after the accept edge.
- Sign combinations:
  - -100/7 -> q=-14, r=-2.
  - 100/-7 -> q=-14, r=2.
  - -100/-7 -> q=14, r=-2.
- Saturation:
  - 5000/3 -> q=255, r=2, overflow=1.
  - -8192/1 -> q=-256, r=0, overflow=1, with no magnitude wrap.
  - 255/1 -> q=255, overflow=0.
- Divide by zero:
  - 37/0 -> q=255, r=0, div_by_zero=1, out_valid 1 cycle after accept.
  - -37/0 -> q=-256.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. After the handshake, out_valid=0 and in_ready=1 the next cycle; a new op is accepted then.
- Reset mid-CALC: assert rst_n=0 at the 6th CALC cycle -> all outputs return to reset values asynchronously. After release, in_ready=1 and no stale out_valid.
